// File: rtl/div_ctrl.sv
// Execute-stage front end for the iterative divider: accepts DIV/REM ops, drives div_unit,
// returns results to writeback, and reuses a one-entry quotient/remainder cache.
module div_ctrl #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic             req_w_i,
  input  logic [XLEN-1:0]  req_rs1_i,
  input  logic [XLEN-1:0]  req_rs2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             div_request_o,
  output logic             div_kill_o,
  output logic             div_int_32_o,
  output logic             div_signed_o,
  output logic [XLEN-1:0]  div_dvnd_o,
  output logic [XLEN-1:0]  div_dvsr_o,
  input  logic             div_stall_i,
  input  logic [XLEN-1:0]  div_quo_i,
  input  logic [XLEN-1:0]  div_rmd_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [XLEN-1:0]  res_data_o,
  output logic [TAG_W-1:0] res_tag_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic              rem_q, rem_d, sgn_q, sgn_d, w_q, w_d;
  logic [XLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, res_q, res_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              c_vld_q, c_vld_d, c_sgn_q, c_sgn_d, c_w_q, c_w_d;
  logic [XLEN-1:0]   c_rs1_q, c_rs1_d, c_rs2_q, c_rs2_d, c_quo_q, c_quo_d, c_rmd_q, c_rmd_d;
  logic              hit;

  // Quotient and remainder are a pure function of operands, signedness and width.
  assign hit = c_vld_q && (c_rs1_q == req_rs1_i) && (c_rs2_q == req_rs2_i) &&
               (c_sgn_q == ~req_op_i[0]) && (c_w_q == req_w_i);

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    sgn_d         = sgn_q;
    w_d           = w_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    tag_d         = tag_q;
    res_d         = res_q;
    c_vld_d       = c_vld_q;
    c_sgn_d       = c_sgn_q;
    c_w_d         = c_w_q;
    c_rs1_d       = c_rs1_q;
    c_rs2_d       = c_rs2_q;
    c_quo_d       = c_quo_q;
    c_rmd_d       = c_rmd_q;
    div_request_o = 1'b0;
    div_kill_o    = 1'b0;
    req_ready_o   = (state_q == IDLE) && !flush_i;
    if (flush_i) begin
      state_d    = IDLE;
      div_kill_o = (state_q == ISSUE) || (state_q == WAIT);
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          rem_d   = req_op_i[1];
          sgn_d   = ~req_op_i[0];
          w_d     = req_w_i;
          rs1_d   = req_rs1_i;
          rs2_d   = req_rs2_i;
          tag_d   = req_tag_i;
          if (hit) begin
            res_d   = req_op_i[1] ? c_rmd_q : c_quo_q;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          div_request_o = 1'b1;
          state_d       = WAIT;
        end
        WAIT: if (!div_stall_i) begin
          res_d   = rem_q ? div_rmd_i : div_quo_i;
          c_vld_d = 1'b1;
          c_sgn_d = sgn_q;
          c_w_d   = w_q;
          c_rs1_d = rs1_q;
          c_rs2_d = rs2_q;
          c_quo_d = div_quo_i;
          c_rmd_d = div_rmd_i;
          state_d = RESP;
        end
        RESP: if (res_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rem_q   <= 1'b0;
      sgn_q   <= 1'b0;
      w_q     <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      tag_q   <= '0;
      res_q   <= '0;
      c_vld_q <= 1'b0;
      c_sgn_q <= 1'b0;
      c_w_q   <= 1'b0;
      c_rs1_q <= '0;
      c_rs2_q <= '0;
      c_quo_q <= '0;
      c_rmd_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      w_q     <= w_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      c_vld_q <= c_vld_d;
      c_sgn_q <= c_sgn_d;
      c_w_q   <= c_w_d;
      c_rs1_q <= c_rs1_d;
      c_rs2_q <= c_rs2_d;
      c_quo_q <= c_quo_d;
      c_rmd_q <= c_rmd_d;
    end
  end

  // Divider controls come straight from the latched op so they hold through the done cycle.
  assign div_int_32_o = w_q;
  assign div_signed_o = sgn_q;
  assign div_dvnd_o   = rs1_q;
  assign div_dvsr_o   = rs2_q;
  assign res_valid_o  = (state_q == RESP);
  assign res_data_o   = res_q;
  assign res_tag_o    = tag_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural divider of programmable latency.
module tb_div_ctrl;
  localparam int XLEN = 64;
  localparam int TAG_W = 6;

  logic clk = 0, rst = 1, flush = 0;
  logic req_valid = 0, req_ready, req_w = 0;
  logic [1:0] req_op = 0;
  logic [XLEN-1:0] req_rs1 = 0, req_rs2 = 0;
  logic [TAG_W-1:0] req_tag = 0;
  logic div_request, div_kill, div_int_32, div_signed, div_stall;
  logic [XLEN-1:0] div_dvnd, div_dvsr, div_quo, div_rmd;
  logic res_valid, res_ready = 0, busy;
  logic [XLEN-1:0] res_data;
  logic [TAG_W-1:0] res_tag;

  int nvec = 0, nerr = 0;
  int lat = 5;
  int req_cnt = 0;
  logic [5:0] cnt;

  always #5 clk = ~clk;

  div_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op), .req_w_i(req_w),
    .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_tag_i(req_tag),
    .div_request_o(div_request), .div_kill_o(div_kill), .div_int_32_o(div_int_32),
    .div_signed_o(div_signed), .div_dvnd_o(div_dvnd), .div_dvsr_o(div_dvsr),
    .div_stall_i(div_stall), .div_quo_i(div_quo), .div_rmd_i(div_rmd),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
    .res_tag_o(res_tag), .busy_o(busy)
  );

  // Behavioural divider: stall for lat cycles after a request, results valid when idle.
  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (div_kill) cnt <= '0;
    else if (div_request) cnt <= lat[5:0];
    else if (cnt != 0) cnt <= cnt - 1'b1;
  end
  assign div_stall = (cnt != 0);

  always @(posedge clk) if (div_request) req_cnt <= req_cnt + 1;

  function automatic logic [63:0] mdl(input logic [63:0] a, input logic [63:0] b,
                                      input logic sg, input logic w, input logic rem);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, r;
    if (w) begin
      sa = sg ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]};
      sb = sg ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]};
    end else begin
      sa = a;
      sb = b;
    end
    ua = sa;
    ub = sb;
    if (ub == 0) r = rem ? ua : '1;
    else if (sg) r = rem ? sa % sb : sa / sb;
    else r = rem ? ua % ub : ua / ub;
    if (w) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  always_comb begin
    div_quo = mdl(div_dvnd, div_dvsr, div_signed, div_int_32, 1'b0);
    div_rmd = mdl(div_dvnd, div_dvsr, div_signed, div_int_32, 1'b1);
  end

  // Presents one op for a single cycle starting at a negedge; reports whether it was ready.
  task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [5:0] tag, output logic rdy);
    req_valid = 1; req_op = op; req_w = 0; req_rs1 = a; req_rs2 = b; req_tag = tag;
    #1 rdy = req_ready;
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic wait_res(output bit ok, output logic pst);
    ok = 0;
    pst = 1'bx;
    for (int i = 0; i < 200; i++) begin
      if (res_valid) begin ok = 1; break; end
      pst = div_stall;
      @(negedge clk);
    end
  endtask

  task automatic handshake();
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    nvec++; if (res_valid !== 1'b0) begin nerr++; $display("FAIL reset_resv: got %b want 0", res_valid); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
    nvec++; if ({div_request, div_kill, div_signed, div_int_32} !== 4'b0) begin nerr++;
      $display("FAIL reset_divctl: got %b want 0000", {div_request, div_kill, div_signed, div_int_32}); end
    nvec++; if ({res_data, res_tag, div_dvnd, div_dvsr} !== '0) begin nerr++;
      $display("FAIL reset_data: got %h/%h want 0", res_data, res_tag); end
  endtask

  task automatic test_div_basic();
    logic rdy, pst; bit ok; int rc0;
    lat = 5; rc0 = req_cnt;
    send(2'b00, 64'd100, 64'd7, 6'd5, rdy);
    nvec++; if (rdy !== 1'b1) begin nerr++; $display("FAIL basic_accept: got %b want 1", rdy); end
    nvec++; if (div_request !== 1'b1) begin nerr++; $display("FAIL basic_issue: got %b want 1", div_request); end
    nvec++; if ({div_signed, div_int_32, div_dvnd, div_dvsr} !== {2'b10, 64'd100, 64'd7}) begin nerr++;
      $display("FAIL basic_ctl: got %b%b %0d %0d want 10 100 7", div_signed, div_int_32, div_dvnd, div_dvsr); end
    wait_res(ok, pst);
    nvec++; if (!ok || pst !== 1'b0) begin nerr++; $display("FAIL basic_timing: got ok=%0d prevstall=%b want 1/0", ok, pst); end
    nvec++; if (res_data !== 64'd14 || res_tag !== 6'd5) begin nerr++;
      $display("FAIL basic_res: got %0d tag %0d want 14 tag 5", res_data, res_tag); end
    nvec++; if (req_cnt !== rc0 + 1) begin nerr++; $display("FAIL basic_reqs: got %0d want %0d", req_cnt - rc0, 1); end
    handshake();
    nvec++; if (busy !== 1'b0 || req_ready !== 1'b1) begin nerr++;
      $display("FAIL basic_idle: got busy %b ready %b want 0 1", busy, req_ready); end
  endtask

  task automatic test_cache_hit();
    logic rdy; int rc0;
    rc0 = req_cnt;
    send(2'b10, 64'd100, 64'd7, 6'd6, rdy);
    nvec++; if (res_valid !== 1'b1 || res_data !== 64'd2 || res_tag !== 6'd6) begin nerr++;
      $display("FAIL hit_rem: got v%b %0d tag %0d want v1 2 tag 6", res_valid, res_data, res_tag); end
    handshake();
    nvec++; if (req_cnt !== rc0) begin nerr++; $display("FAIL hit_noreq: got %0d want 0", req_cnt - rc0); end
  endtask

  task automatic test_signedness();
    logic rdy, pst; bit ok; int rc0;
    rc0 = req_cnt;
    send(2'b01, 64'd100, 64'd7, 6'd7, rdy);
    nvec++; if (div_request !== 1'b1 || div_signed !== 1'b0) begin nerr++;
      $display("FAIL divu_miss: got req %b sgn %b want 1 0", div_request, div_signed); end
    wait_res(ok, pst);
    nvec++; if (!ok || res_data !== 64'd14) begin nerr++; $display("FAIL divu_res: got %0d want 14", res_data); end
    handshake();
    send(2'b11, 64'd100, 64'd7, 6'd8, rdy);
    nvec++; if (res_valid !== 1'b1 || res_data !== 64'd2 || req_cnt !== rc0 + 1) begin nerr++;
      $display("FAIL remu_hit: got v%b %0d reqs %0d want v1 2 reqs 1", res_valid, res_data, req_cnt - rc0); end
    handshake();
    send(2'b00, 64'hFFFF_FFFF_FFFF_FFFB, 64'd2, 6'd9, rdy);
    nvec++; if (div_request !== 1'b1) begin nerr++; $display("FAIL div_neg_miss: got %b want 1", div_request); end
    wait_res(ok, pst);
    nvec++; if (!ok || res_data !== 64'hFFFF_FFFF_FFFF_FFFE || res_tag !== 6'd9) begin nerr++;
      $display("FAIL div_neg_res: got %h tag %0d want fffffffffffffffe tag 9", res_data, res_tag); end
    handshake();
  endtask

  task automatic test_flush_wait();
    logic rdy; int rc0;
    lat = 30;
    send(2'b00, 64'd1000, 64'd3, 6'd10, rdy);
    repeat (10) @(negedge clk);
    nvec++; if (div_request !== 1'b0 || div_dvnd !== 64'd1000 || div_dvsr !== 64'd3) begin nerr++;
      $display("FAIL wait_hold: got req %b %0d/%0d want 0 1000/3", div_request, div_dvnd, div_dvsr); end
    flush = 1;
    #1;
    nvec++; if (div_kill !== 1'b1 || req_ready !== 1'b0) begin nerr++;
      $display("FAIL flush_kill: got kill %b ready %b want 1 0", div_kill, req_ready); end
    @(negedge clk);
    flush = 0;
    #1;
    nvec++; if (busy !== 1'b0 || res_valid !== 1'b0 || div_kill !== 1'b0) begin nerr++;
      $display("FAIL flush_idle: got busy %b v %b kill %b want 000", busy, res_valid, div_kill); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nvec++; if (res_valid !== 1'b0) begin nerr++; $display("FAIL flush_nores: got %b want 0", res_valid); end
    end
    rc0 = req_cnt;
    send(2'b10, 64'hFFFF_FFFF_FFFF_FFFB, 64'd2, 6'd11, rdy);
    nvec++; if (res_valid !== 1'b1 || res_data !== 64'hFFFF_FFFF_FFFF_FFFF || req_cnt !== rc0) begin nerr++;
      $display("FAIL flush_cache: got v%b %h reqs %0d want v1 ffffffffffffffff reqs 0", res_valid, res_data, req_cnt - rc0); end
    handshake();
  endtask

  task automatic test_flush_idle();
    req_valid = 1; req_op = 2'b00; req_rs1 = 64'd50; req_rs2 = 64'd5; req_tag = 6'd12;
    flush = 1;
    #1;
    nvec++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL flush_idle_rdy: got %b want 0", req_ready); end
    @(negedge clk);
    flush = 0; req_valid = 0;
    #1;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL flush_idle_acc: got busy %b want 0", busy); end
  endtask

  task automatic test_flush_done();
    logic rdy, pst; bit ok; int rc0;
    lat = 4;
    send(2'b00, 64'd9, 64'd2, 6'd13, rdy);
    @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      if (!div_stall) break;
      @(negedge clk);
    end
    flush = 1;
    @(negedge clk);
    flush = 0;
    #1;
    nvec++; if (res_valid !== 1'b0 || busy !== 1'b0) begin nerr++;
      $display("FAIL flushdone_drop: got v%b busy %b want 0 0", res_valid, busy); end
    rc0 = req_cnt;
    send(2'b10, 64'd9, 64'd2, 6'd14, rdy);
    nvec++; if (div_request !== 1'b1) begin nerr++; $display("FAIL flushdone_nocache: got %b want 1", div_request); end
    wait_res(ok, pst);
    nvec++; if (!ok || res_data !== 64'd1 || req_cnt !== rc0 + 1) begin nerr++;
      $display("FAIL flushdone_res: got %0d reqs %0d want 1 reqs 1", res_data, req_cnt - rc0); end
    handshake();
  endtask

  task automatic test_back_to_back();
    logic rdy, pst; bit ok;
    lat = 3;
    send(2'b00, 64'd200, 64'd10, 6'd20, rdy);
    wait_res(ok, pst);
    req_valid = 1; req_op = 2'b10; req_rs1 = 64'd200; req_rs2 = 64'd10; req_tag = 6'd21;
    for (int i = 0; i < 5; i++) begin
      #1;
      nvec++; if (res_valid !== 1'b1 || res_data !== 64'd20 || res_tag !== 6'd20 || req_ready !== 1'b0) begin nerr++;
        $display("FAIL hold_stable: got v%b %0d tag %0d rdy %b want v1 20 tag 20 rdy 0", res_valid, res_data, res_tag, req_ready); end
      @(negedge clk);
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    #1;
    nvec++; if (req_ready !== 1'b1 || res_valid !== 1'b0) begin nerr++;
      $display("FAIL b2b_ready: got rdy %b v %b want 1 0", req_ready, res_valid); end
    @(negedge clk);
    req_valid = 0;
    nvec++; if (res_valid !== 1'b1 || res_data !== 64'd0 || res_tag !== 6'd21) begin nerr++;
      $display("FAIL b2b_res: got v%b %0d tag %0d want v1 0 tag 21", res_valid, res_data, res_tag); end
    handshake();
  endtask

  task automatic test_reset_mid();
    logic rdy, pst; bit ok; int rc0;
    lat = 20;
    send(2'b00, 64'd77, 64'd5, 6'd3, rdy);
    repeat (5) @(negedge clk);
    rst = 1;
    #1;
    nvec++; if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || div_request !== 1'b0 ||
                div_dvnd !== 64'd0 || res_tag !== 6'd0) begin nerr++;
      $display("FAIL rstmid_outs: got v%b busy %b rdy %b req %b dvnd %0d want 0 0 1 0 0", res_valid, busy, req_ready, div_request, div_dvnd); end
    @(negedge clk);
    rst = 0;
    lat = 3;
    send(2'b00, 64'd100, 64'd7, 6'd4, rdy);
    nvec++; if (div_request !== 1'b1) begin nerr++; $display("FAIL rstmid_cache: got %b want 1", div_request); end
    wait_res(ok, pst);
    nvec++; if (!ok || res_data !== 64'd14 || res_tag !== 6'd4) begin nerr++;
      $display("FAIL rstmid_res: got %0d tag %0d want 14 tag 4", res_data, res_tag); end
    handshake();
    rc0 = req_cnt;
    send(2'b00, 64'd77, 64'd5, 6'd5, rdy);
    wait_res(ok, pst);
    nvec++; if (!ok || res_data !== 64'd15 || req_cnt !== rc0 + 1) begin nerr++;
      $display("FAIL rstmid_redo: got %0d reqs %0d want 15 reqs 1", res_data, req_cnt - rc0); end
    handshake();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_div_basic();
    test_cache_hit();
    test_signedness();
    test_flush_wait();
    test_flush_idle();
    test_flush_done();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
